kc705_icap_multiboot_ctrl: RTL and testbench

//  Multiboot controller for the KC705 demo images. Drives the ICAPE2 primitive with
//  the IPROG command sequence that reloads the FPGA from flash at WBSTAR_ADDR.
//  A debounced dip_sw0 rising edge or a boot_req pulse starts the sequence.

---
 rtl/kc705_icap_pkg.sv | 48 ++++
 rtl/kc705_icap_multiboot_ctrl_sw_debounce.sv | 55 +++++
 rtl/kc705_icap_multiboot_ctrl.sv | 111 +++++++++++
 tb/tb_kc705_icap_multiboot_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kc705_icap_pkg.sv
// Shared constants, state encoding and helpers for the KC705 ICAPE2 multiboot controller.
package kc705_icap_pkg;

    localparam int unsigned IPROG_LEN = 9;

    localparam logic [31:0] CMD_DUMMY     = 32'hFFFF_FFFF;
    localparam logic [31:0] CMD_SYNC      = 32'hAA99_5566;
    localparam logic [31:0] CMD_NOOP      = 32'h2000_0000;
    localparam logic [31:0] CMD_WR_WBSTAR = 32'h3002_0001;
    localparam logic [31:0] CMD_WR_CMD    = 32'h3000_8001;
    localparam logic [31:0] CMD_IPROG     = 32'h0000_000F;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        SEQ      = 2'd2,
        DONE     = 2'd3
    } mb_state_t;

    // ICAPE2 expects each byte bit-reversed; byte order is kept.
    function automatic logic [31:0] bitswap32(input logic [31:0] word);
        logic [31:0] swapped;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                swapped[8*b + i] = word[8*b + 7 - i];
            end
        end
        return swapped;
    endfunction

    function automatic logic [31:0] iprog_word(input logic [3:0] idx, input logic [31:0] wbstar);
        logic [31:0] word;
        case (idx)
            4'd0:    word = CMD_DUMMY;
            4'd1:    word = CMD_SYNC;
            4'd2:    word = CMD_NOOP;
            4'd3:    word = CMD_WR_WBSTAR;
            4'd4:    word = wbstar;
            4'd5:    word = CMD_NOOP;
            4'd6:    word = CMD_WR_CMD;
            4'd7:    word = CMD_IPROG;
            4'd8:    word = CMD_NOOP;
            default: word = CMD_NOOP;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/kc705_icap_multiboot_ctrl_sw_debounce.sv
// Two-flop synchroniser plus counter debounce for a slow mechanical switch, with a rise pulse.
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_sync,
    output logic sw_stable,
    output logic sw_rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser resets high so an unseen switch is treated as possibly on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= sw_raw;
            sync2_r <= sync1_r;
        end
    end

    // Stable value only flips after the synchronised input disagrees for the full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            rise_r   <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r  <= {CNT_W{1'b0}};
            rise_r <= 1'b0;
        end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_r <= sync2_r;
            cnt_r    <= {CNT_W{1'b0}};
            rise_r   <= sync2_r;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            rise_r <= 1'b0;
        end
    end

    assign sw_sync   = sync2_r;
    assign sw_stable = stable_r;
    assign sw_rise   = rise_r;

endmodule

// File: rtl/kc705_icap_multiboot_ctrl.sv
// Issues the ICAPE2 IPROG sequence (warm boot from WBSTAR_ADDR) on a switch rise or boot_req.
module kc705_icap_multiboot_ctrl
    import kc705_icap_pkg::*;
#(
    parameter logic [31:0] WBSTAR_ADDR     = 32'h0080_0000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        dip_sw0,
    input  logic        boot_req,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_i,
    output logic        armed,
    output logic        busy
);

    logic sw_sync_s;
    logic sw_stable_s;
    logic sw_rise_s;

    sw_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk       (clk_100m),
        .rst       (rst),
        .sw_raw    (dip_sw0),
        .sw_sync   (sw_sync_s),
        .sw_stable (sw_stable_s),
        .sw_rise   (sw_rise_s)
    );

    mb_state_t   state_r;
    logic [3:0]  idx_r;
    logic        csib_r;
    logic        rdwrb_r;
    logic [31:0] icap_i_r;
    logic        armed_r;
    logic        busy_r;

    // Arming needs the switch both debounced low and currently low, so a high power-up switch never reloads.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_r  <= WAIT_LOW;
            idx_r    <= 4'd0;
            csib_r   <= 1'b1;
            rdwrb_r  <= 1'b1;
            icap_i_r <= 32'h0000_0000;
            armed_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                WAIT_LOW: begin
                    if (!sw_stable_s && !sw_sync_s) begin
                        state_r <= ARMED;
                        armed_r <= 1'b1;
                    end else begin
                        state_r <= WAIT_LOW;
                    end
                end
                ARMED: begin
                    if (sw_rise_s || boot_req) begin
                        state_r  <= SEQ;
                        armed_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        csib_r   <= 1'b0;
                        rdwrb_r  <= 1'b0;
                        icap_i_r <= bitswap32(iprog_word(4'd0, WBSTAR_ADDR));
                        idx_r    <= 4'd1;
                    end else begin
                        state_r <= ARMED;
                    end
                end
                // idx_r names the next word to present; the first word went out on entry.
                SEQ: begin
                    if (idx_r == 4'(IPROG_LEN)) begin
                        state_r  <= DONE;
                        busy_r   <= 1'b0;
                        csib_r   <= 1'b1;
                        rdwrb_r  <= 1'b1;
                        icap_i_r <= 32'h0000_0000;
                        idx_r    <= 4'd0;
                    end else begin
                        icap_i_r <= bitswap32(iprog_word(idx_r, WBSTAR_ADDR));
                        idx_r    <= idx_r + 4'd1;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r  <= WAIT_LOW;
                    idx_r    <= 4'd0;
                    csib_r   <= 1'b1;
                    rdwrb_r  <= 1'b1;
                    icap_i_r <= 32'h0000_0000;
                    armed_r  <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign icap_csib  = csib_r;
    assign icap_rdwrb = rdwrb_r;
    assign icap_i     = icap_i_r;
    assign armed      = armed_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_kc705_icap_multiboot_ctrl.sv
// Directed bench for the multiboot controller; a second instance covers a different WBSTAR_ADDR.
module tb_kc705_icap_multiboot_ctrl;

    logic        clk_100m = 1'b0;
    logic        rst      = 1'b0;
    logic        dip_sw0  = 1'b0;
    logic        boot_req = 1'b0;

    logic        csib_a, rdwrb_a, armed_a, busy_a;
    logic [31:0] icap_i_a;
    logic        csib_b, rdwrb_b, armed_b, busy_b;
    logic [31:0] icap_i_b;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Expected byte-bit-reversed IPROG words, worked by hand for WBSTAR 0080_0000.
    logic [31:0] exp_words [0:8] = '{
        32'hFFFF_FFFF, 32'h5599_AA66, 32'h0400_0000,
        32'h0C40_0080, 32'h0001_0000, 32'h0400_0000,
        32'h0C00_0180, 32'h0000_00F0, 32'h0400_0000
    };

    kc705_icap_multiboot_ctrl #(
        .WBSTAR_ADDR     (32'h0080_0000),
        .DEBOUNCE_CYCLES (4)
    ) dut_a (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .dip_sw0    (dip_sw0),
        .boot_req   (boot_req),
        .icap_csib  (csib_a),
        .icap_rdwrb (rdwrb_a),
        .icap_i     (icap_i_a),
        .armed      (armed_a),
        .busy       (busy_a)
    );

    kc705_icap_multiboot_ctrl #(
        .WBSTAR_ADDR     (32'h0100_0000),
        .DEBOUNCE_CYCLES (4)
    ) dut_b (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .dip_sw0    (dip_sw0),
        .boot_req   (boot_req),
        .icap_csib  (csib_b),
        .icap_rdwrb (rdwrb_b),
        .icap_i     (icap_i_b),
        .armed      (armed_b),
        .busy       (busy_b)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_armed(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (armed_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        bit ok;
        dip_sw0 = 1'b1;
        rst     = 1'b1;
        #3;
        check_cnt++;
        if ({csib_a, rdwrb_a, icap_i_a, armed_a, busy_a, csib_b, rdwrb_b, armed_b, busy_b}
            !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_values: csib=%b rdwrb=%b icap_i=%h armed=%b busy=%b (b: %b %b %b %b) need 1 1 0 0 0",
                     csib_a, rdwrb_a, icap_i_a, armed_a, busy_a, csib_b, rdwrb_b, armed_b, busy_b);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (armed_a !== 1'b0 || csib_a !== 1'b1) bad++;
        end
        check_cnt++;
        if (bad != 0) $display("FAIL switch_high_no_arm: %0d bad cycles, need 0", bad);
        else pass_cnt++;
        dip_sw0 = 1'b0;
        wait_armed(8, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL arm_after_low: armed=%b, need 1 within 8 cycles", armed_a);
        else pass_cnt++;
    endtask

    task automatic test_boot_req();
        int bad;
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        check_cnt++;
        if (csib_a !== 1'b0 || rdwrb_a !== 1'b0 || busy_a !== 1'b1 || icap_i_a !== 32'hFFFF_FFFF)
            $display("FAIL first_word: csib=%b rdwrb=%b busy=%b icap_i=%h, need 0 0 1 ffffffff",
                     csib_a, rdwrb_a, busy_a, icap_i_a);
        else pass_cnt++;
        bad = 0;
        for (int i = 1; i < 9; i++) begin
            tick();
            if (csib_a !== 1'b0 || icap_i_a !== exp_words[i]) begin
                $display("FAIL seq_word_%0d: csib=%b icap_i=%h, need 0 %h", i, csib_a, icap_i_a, exp_words[i]);
                bad++;
            end
            if (i == 4) begin
                check_cnt++;
                if (csib_b !== 1'b0 || icap_i_b !== 32'h8000_0000)
                    $display("FAIL wbstar_alt: csib=%b icap_i=%h, need 0 80000000", csib_b, icap_i_b);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (bad == 0) pass_cnt++;
        tick();
        check_cnt++;
        if (csib_a !== 1'b1 || rdwrb_a !== 1'b1 || busy_a !== 1'b0 || armed_a !== 1'b0)
            $display("FAIL seq_end: csib=%b rdwrb=%b busy=%b armed=%b, need 1 1 0 0",
                     csib_a, rdwrb_a, busy_a, armed_a);
        else pass_cnt++;
    endtask

    task automatic test_switch_trigger();
        int low_cnt, falls, bad;
        bit ok;
        logic prev;
        do_reset();
        wait_armed(10, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL rearm: armed=%b, need 1", armed_a);
        else pass_cnt++;
        dip_sw0 = 1'b1;
        tick();
        tick();
        dip_sw0 = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (csib_a !== 1'b1 || armed_a !== 1'b1) bad++;
        end
        check_cnt++;
        if (bad != 0) $display("FAIL glitch_ignored: %0d bad cycles, need 0", bad);
        else pass_cnt++;
        dip_sw0 = 1'b1;
        low_cnt = 0;
        falls   = 0;
        prev    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (csib_a === 1'b0) low_cnt++;
            if (prev === 1'b1 && csib_a === 1'b0) falls++;
            prev = csib_a;
        end
        check_cnt++;
        if (low_cnt != 9 || falls != 1)
            $display("FAIL switch_sequence: low=%0d starts=%0d, need 9 1", low_cnt, falls);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_seq();
        int bad;
        bit ok;
        dip_sw0 = 1'b0;
        do_reset();
        wait_armed(10, ok);
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        tick();
        tick();
        tick();
        check_cnt++;
        if (csib_a !== 1'b0 || icap_i_a !== 32'h0C40_0080)
            $display("FAIL pre_abort_idx3: csib=%b icap_i=%h, need 0 0c400080", csib_a, icap_i_a);
        else pass_cnt++;
        dip_sw0 = 1'b1;
        rst = 1'b1;
        #1;
        check_cnt++;
        if (csib_a !== 1'b1 || icap_i_a !== 32'h0 || busy_a !== 1'b0)
            $display("FAIL abort_immediate: csib=%b icap_i=%h busy=%b, need 1 0 0", csib_a, icap_i_a, busy_a);
        else pass_cnt++;
        tick();
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (csib_a !== 1'b1 || armed_a !== 1'b0) bad++;
        end
        check_cnt++;
        if (bad != 0) $display("FAIL no_resume: %0d bad cycles, need 0", bad);
        else pass_cnt++;
        dip_sw0 = 1'b0;
        wait_armed(8, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL rearm_after_abort: armed=%b, need 1", armed_a);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int low_cnt, bad;
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        low_cnt = (csib_a === 1'b0) ? 1 : 0;
        for (int i = 0; i < 14; i++) begin
            boot_req = (i == 2 || i == 5) ? 1'b1 : 1'b0;
            tick();
            if (csib_a === 1'b0) low_cnt++;
        end
        boot_req = 1'b0;
        check_cnt++;
        if (low_cnt != 9) $display("FAIL req_during_seq: low=%0d, need 9", low_cnt);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            boot_req = (i % 3 == 0) ? 1'b1 : 1'b0;
            tick();
            if (csib_a !== 1'b1 || busy_a !== 1'b0 || armed_a !== 1'b0) bad++;
        end
        boot_req = 1'b0;
        check_cnt++;
        if (bad != 0) $display("FAIL req_in_done: %0d bad cycles, need 0", bad);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_boot_req();
        test_switch_trigger();
        test_reset_mid_seq();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
